sd_req_arbiter: RTL and testbench
=================================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd10_000_000: max clk_sys cycles in ISSUE before abort.
REQ-002 Parameter BUFW, default 9: width of the SD buffer byte address.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 c0_lba, c1_lba  in  32 each  client 0/1 sector LBA, valid while that client's rd or wr is high.
REQ-006 c0_rd, c0_wr, c1_rd, c1_wr  in  1 each  client sector read/write request levels.
REQ-007 c0_buff_din, c1_buff_din  in  8 each  client write data, toward SD.
REQ-008 c0_ack, c1_ack  out  1 each  per-client transfer acknowledge.
REQ-009 c0_buff_wr, c1_buff_wr  out  1 each  per-client buffer write strobe.
REQ-010 c0_err, c1_err  out  1 each  one-cycle timeout-abort pulse.
REQ-011 cl_buff_addr  out  BUFW  SD buffer address, broadcast to both clients.
REQ-012 cl_buff_dout  out  8  SD read data, broadcast to both clients.
REQ-013 sd_lba  out  32;  sd_rd, sd_wr  out  1 each  request to the SD host.
REQ-014 sd_ack  in  1;  sd_buff_addr  in  BUFW;  sd_buff_dout  in  8;  sd_buff_wr  in  1  SD host side.
REQ-015 sd_buff_din  out  8  write data to the SD host, muxed from the granted client.

Function
REQ-016 FSM states: IDLE, ISSUE, XFER, RELEASE. The FSM is registered and occupies exactly one state per cycle.
REQ-017 IDLE: req0=c0_rd|c0_wr, req1=c1_rd|c1_wr. With one request, grant that client. With both, grant the client selected by the prio bit (0 selects client 0).
REQ-018 On grant: latch gnt, latched_lba, dir_wr=(client wr), go to ISSUE next cycle.
REQ-019 If a client raises rd and wr together, treat it as a read (dir_wr=0).
REQ-020 ISSUE: drive sd_lba=latched_lba and sd_rd=~dir_wr, sd_wr=dir_wr, registered. Clear the timeout counter on entry and increment it each cycle.
REQ-021 ISSUE -> XFER on the first cycle sd_ack=1. sd_rd/sd_wr drop to 0 on the next edge.
REQ-022 ISSUE -> IDLE when the counter reaches TIMEOUT-1 with sd_ack=0. Pulse the granted cN_err for one cycle, deassert sd_rd/sd_wr, and do not toggle prio.
REQ-023 XFER: route sd_ack to the granted cN_ack and sd_buff_wr to the granted cN_buff_wr, combinationally. The non-granted ack and buff_wr stay 0.
REQ-024 sd_buff_din = granted client's buff_din (combinational, all states); value is 8'h00 in IDLE.
REQ-025 cl_buff_addr=sd_buff_addr and cl_buff_dout=sd_buff_dout pass through unconditionally.
REQ-026 XFER -> RELEASE on the first cycle sd_ack=0.
REQ-027 RELEASE: lasts one cycle, sets prio to ~gnt, then goes to IDLE.
REQ-028 Requests still high in RELEASE are not sampled. A client holding rd/wr after its ack falls is re-granted only per REQ-017 in IDLE.
REQ-029 Client request changes after grant (lba/rd/wr) are ignored until the FSM returns to IDLE.
REQ-030 sd_ack=1 while in IDLE or RELEASE is ignored; it is not routed to any client.
REQ-031 sd_buff_wr outside XFER is not routed to any client.

Reset
REQ-032 reset_n=0 asynchronously forces: state=IDLE, gnt=0, prio=0, dir_wr=0, counter=0, latched_lba=0.
REQ-033 Under reset, outputs are: sd_rd=0, sd_wr=0, sd_lba=0, all cN_ack=0, cN_buff_wr=0, cN_err=0, sd_buff_din=0.
REQ-034 Reset deassertion takes effect on the next rising clk_sys. A reset during a transfer abandons it with no err pulse.

Verification
REQ-035 Single read: c0_rd=1, c0_lba=32'h10 -> sd_rd=1 and sd_lba=32'h10 two edges later. sd_ack high for 512 sd_buff_wr pulses -> c0_ack high and 512 c0_buff_wr pulses; c1_* stay 0.
REQ-036 Contention: c0_rd and c1_wr asserted in the same cycle after reset -> client 0 served first. With both still requesting, client 1 is served next with sd_wr=1, and prio ends at 0.
REQ-037 Timeout: TIMEOUT=16, c1_rd=1, sd_ack held 0 -> c1_err pulses exactly once, 16 cycles after ISSUE entry, and sd_rd returns to 0.
REQ-038 Write data mux: grant client 1 write, c1_buff_din=8'hA5 -> sd_buff_din=8'hA5 during XFER; c0_buff_din has no effect.
REQ-039 Reset mid-XFER: reset_n=0 while sd_ack=1 -> all outputs 0 immediately. After release with no requests, the FSM stays in IDLE and a stray sd_ack produces no cN_ack.
REQ-040 rd+wr same cycle on client 0 -> sd_rd=1, sd_wr=0.

Source files
------------

// File: rtl/sd_req_arbiter_if.sv
// SD host-side bus between the request arbiter (master) and the SD host (slave).
// Ports: sd_lba/sd_rd/sd_wr/sd_buff_din toward host; sd_ack/sd_buff_* from host.
interface sd_req_arbiter_if #(
    parameter int BUFW = 9
);
    logic [31:0]     sd_lba;
    logic            sd_rd;
    logic            sd_wr;
    logic [7:0]      sd_buff_din;
    logic            sd_ack;
    logic [BUFW-1:0] sd_buff_addr;
    logic [7:0]      sd_buff_dout;
    logic            sd_buff_wr;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Two-client arbiter sharing one SD host: grants one sector read/write at a time.
// Ports: clk_sys, reset_n; client c0_*/c1_* request, ack, strobe, err; sd host bus.
module sd_req_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000,
    parameter int          BUFW    = 9
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [31:0]      c0_lba,
    input  logic [31:0]      c1_lba,
    input  logic             c0_rd,
    input  logic             c0_wr,
    input  logic             c1_rd,
    input  logic             c1_wr,
    input  logic [7:0]       c0_buff_din,
    input  logic [7:0]       c1_buff_din,
    output logic             c0_ack,
    output logic             c1_ack,
    output logic             c0_buff_wr,
    output logic             c1_buff_wr,
    output logic             c0_err,
    output logic             c1_err,
    output logic [BUFW-1:0]  cl_buff_addr,
    output logic [7:0]       cl_buff_dout,
    sd_req_arbiter_if.master sd
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        prio_q, prio_d;
    logic        dir_wr_q, dir_wr_d;
    logic [31:0] lba_q, lba_d;
    logic [23:0] cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  err_q, err_d;

    logic req0, req1, sel, in_xfer;

    assign req0 = c0_rd | c0_wr;
    assign req1 = c1_rd | c1_wr;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        dir_wr_d = dir_wr_q;
        lba_d    = lba_q;
        cnt_d    = cnt_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        err_d    = 2'b00;
        sel      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 || req1) begin
                    // Both requesting: prio picks; otherwise the lone requester.
                    sel      = (req0 && req1) ? prio_q : req1;
                    gnt_d    = sel;
                    lba_d    = sel ? c1_lba : c0_lba;
                    // rd+wr together is treated as a read.
                    dir_wr_d = sel ? (c1_wr & ~c1_rd) : (c0_wr & ~c0_rd);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (sd.sd_ack) begin
                    state_d = XFER;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    // Abort: flag the granted client, prio left untouched.
                    state_d        = IDLE;
                    err_d[gnt_q]   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                    rd_d  = ~dir_wr_q;
                    wr_d  = dir_wr_q;
                end
            end
            XFER: begin
                if (!sd.sd_ack) state_d = RELEASE;
            end
            RELEASE: begin
                prio_d  = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            dir_wr_q <= 1'b0;
            lba_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            prio_q   <= prio_d;
            dir_wr_q <= dir_wr_d;
            lba_q    <= lba_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end

    assign in_xfer = (state_q == XFER);

    assign c0_ack     = in_xfer & ~gnt_q & sd.sd_ack;
    assign c1_ack     = in_xfer &  gnt_q & sd.sd_ack;
    assign c0_buff_wr = in_xfer & ~gnt_q & sd.sd_buff_wr;
    assign c1_buff_wr = in_xfer &  gnt_q & sd.sd_buff_wr;
    assign c0_err     = err_q[0];
    assign c1_err     = err_q[1];

    assign cl_buff_addr = sd.sd_buff_addr;
    assign cl_buff_dout = sd.sd_buff_dout;

    assign sd.sd_lba      = lba_q;
    assign sd.sd_rd       = rd_q;
    assign sd.sd_wr       = wr_q;
    assign sd.sd_buff_din = (state_q == IDLE) ? 8'h00
                          : (gnt_q ? c1_buff_din : c0_buff_din);

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: read, contention, data mux, reset, timeout.
// Drives on negedge, samples on negedge; summary line counts failed checks.
module tb_sd_req_arbiter;
    localparam int BUFW = 9;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [31:0]     c0_lba = '0, c1_lba = '0;
    logic            c0_rd = 0, c0_wr = 0, c1_rd = 0, c1_wr = 0;
    logic [7:0]      c0_buff_din = '0, c1_buff_din = '0;
    logic            c0_ack, c1_ack, c0_buff_wr, c1_buff_wr, c0_err, c1_err;
    logic [BUFW-1:0] cl_buff_addr;
    logic [7:0]      cl_buff_dout;

    int errors = 0;
    int checks = 0;

    sd_req_arbiter_if #(.BUFW(BUFW)) sd ();

    sd_req_arbiter #(.TIMEOUT(24'd16), .BUFW(BUFW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .c0_lba(c0_lba), .c1_lba(c1_lba),
        .c0_rd(c0_rd), .c0_wr(c0_wr), .c1_rd(c1_rd), .c1_wr(c1_wr),
        .c0_buff_din(c0_buff_din), .c1_buff_din(c1_buff_din),
        .c0_ack(c0_ack), .c1_ack(c1_ack),
        .c0_buff_wr(c0_buff_wr), .c1_buff_wr(c1_buff_wr),
        .c0_err(c0_err), .c1_err(c1_err),
        .cl_buff_addr(cl_buff_addr), .cl_buff_dout(cl_buff_dout),
        .sd(sd.master)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rdwr"}, {30'd0, sd.sd_rd, sd.sd_wr}, 32'd0);
        chk({tag, "_lba"}, sd.sd_lba, 32'd0);
        chk({tag, "_acks"},
            {26'd0, c0_ack, c1_ack, c0_buff_wr, c1_buff_wr, c0_err, c1_err},
            32'd0);
        chk({tag, "_din"}, {24'd0, sd.sd_buff_din}, 32'd0);
    endtask

    int c0_pulses, other_hits, err_at, err_cnt;

    initial begin
        sd.sd_ack = 0;
        sd.sd_buff_addr = '0;
        sd.sd_buff_dout = '0;
        sd.sd_buff_wr = 0;
        #2;
        chk_idle_outs("reset");
        step(2);
        reset_n = 1'b1;

        // Single read on client 0
        c0_rd = 1; c0_lba = 32'h10;
        step(1);
        chk("rd_edge1", {31'd0, sd.sd_rd}, 32'd0);
        step(1);
        chk("rd_edge2", {31'd0, sd.sd_rd}, 32'd1);
        chk("rd_wr0", {31'd0, sd.sd_wr}, 32'd0);
        chk("rd_lba", sd.sd_lba, 32'h10);
        c0_rd = 0;
        sd.sd_ack = 1;
        step(1);
        chk("rd_drop", {31'd0, sd.sd_rd}, 32'd0);
        chk("rd_c0ack", {31'd0, c0_ack}, 32'd1);
        c0_pulses = 0;
        other_hits = 0;
        for (int i = 0; i < 1024; i++) begin
            sd.sd_buff_wr = ~i[0];
            sd.sd_buff_addr = 9'(i >> 1);
            sd.sd_buff_dout = 8'(i);
            #1;
            if (c0_buff_wr) c0_pulses++;
            if (c1_buff_wr || c1_ack || !c0_ack) other_hits++;
            if (i == 601) begin
                chk("addr_pass", {23'd0, cl_buff_addr}, 32'd300);
                chk("dout_pass", {24'd0, cl_buff_dout}, 32'h59);
            end
            step(1);
        end
        sd.sd_buff_wr = 0;
        chk("rd_pulses", c0_pulses, 512);
        chk("rd_c1_quiet", other_hits, 0);
        sd.sd_ack = 0;
        step(1);
        chk("rel_c0ack", {31'd0, c0_ack}, 32'd0);
        sd.sd_ack = 1;
        step(1);
        chk("rel_stray", {30'd0, c0_ack, c1_ack}, 32'd0);
        sd.sd_ack = 0;
        step(2);

        // Contention after reset: client 0 first, then client 1 write
        reset_n = 0;
        step(1);
        reset_n = 1;
        c0_rd = 1; c0_lba = 32'hA0;
        c1_wr = 1; c1_lba = 32'hB1;
        step(2);
        chk("cont0_rd", {30'd0, sd.sd_rd, sd.sd_wr}, 32'd2);
        chk("cont0_lba", sd.sd_lba, 32'hA0);
        sd.sd_ack = 1;
        step(1);
        chk("cont0_ack", {30'd0, c0_ack, c1_ack}, 32'd2);
        sd.sd_ack = 0;
        step(4);
        chk("cont1_wr", {30'd0, sd.sd_rd, sd.sd_wr}, 32'd1);
        chk("cont1_lba", sd.sd_lba, 32'hB1);
        sd.sd_ack = 1;
        c1_buff_din = 8'hA5;
        c0_buff_din = 8'h5A;
        step(1);
        sd.sd_buff_wr = 1;
        #1;
        chk("mux_din", {24'd0, sd.sd_buff_din}, 32'hA5);
        chk("cont1_route",
            {28'd0, c0_ack, c1_ack, c0_buff_wr, c1_buff_wr}, 32'b0101);
        c0_buff_din = 8'hFF;
        #1;
        chk("mux_c0_noeff", {24'd0, sd.sd_buff_din}, 32'hA5);
        step(1);
        sd.sd_buff_wr = 0;
        c0_rd = 0; c1_wr = 0;
        sd.sd_ack = 0;
        step(2);
        chk("idle_din", {24'd0, sd.sd_buff_din}, 32'd0);
        // prio should be back at client 0
        c0_rd = 1; c1_wr = 1;
        step(2);
        chk("prio0_lba", sd.sd_lba, 32'hA0);
        chk("prio0_rd", {30'd0, sd.sd_rd, sd.sd_wr}, 32'd2);

        // Reset mid-XFER
        sd.sd_ack = 1;
        step(1);
        chk("mid_ack", {31'd0, c0_ack}, 32'd1);
        #2;
        reset_n = 0;
        #1;
        chk_idle_outs("midrst");
        c0_rd = 0; c1_wr = 0;
        step(1);
        reset_n = 1;
        step(3);
        chk("stray_ack", {30'd0, c0_ack, c1_ack}, 32'd0);
        chk("stray_rd", {30'd0, sd.sd_rd, sd.sd_wr}, 32'd0);
        chk("stray_err", {30'd0, c0_err, c1_err}, 32'd0);
        sd.sd_ack = 0;

        // rd+wr together on client 0 is a read
        c0_rd = 1; c0_wr = 1; c0_lba = 32'h77;
        step(2);
        chk("rdwr_dir", {30'd0, sd.sd_rd, sd.sd_wr}, 32'd2);
        c0_rd = 0; c0_wr = 0;
        reset_n = 0;
        step(1);
        reset_n = 1;

        // Timeout on client 1
        c1_rd = 1; c1_lba = 32'h55;
        err_at = -1;
        err_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (k == 16) chk("to_rd_hi", {31'd0, sd.sd_rd}, 32'd1);
            if (c0_err) err_cnt += 100;
            if (c1_err) begin
                err_cnt++;
                if (err_at < 0) begin
                    err_at = k;
                    chk("to_rd_lo", {31'd0, sd.sd_rd}, 32'd0);
                end
                c1_rd = 0;
            end
        end
        chk("to_at", err_at, 17);
        chk("to_once", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
